sfp_acc_bank: RTL and testbench
===============================

# sfp_acc_bank

Parametrised multi-channel special-function stage for the corelet output path, generalising the single-register accumulate/ReLU SFP into a buffered accumulation bank. Consumes psum vectors read from the OFIFO, accumulates `kij` passes of `len` output pixels per channel in an internal bank, then drains ReLU'd, saturated results toward the PSUM SRAM under a valid/ready handshake. Sits between `ofifo` and the PSUM memory write port inside the corelet.

## Interface

- `col`, 8, channel count (one lane per MAC-array column)
- `psum_bw`, 16, signed psum width in and out
- `acc_bw`, 20, signed internal accumulator width; must be ≥ `psum_bw`
- `depth`, 16, bank entries (output pixels) per channel
- `kij_max`, 9, maximum accumulation passes
- One clock `clk`; reset `reset` is synchronous and active-low.
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous active-low reset
- `cfg_start` in 1: start a job; sampled only in IDLE
- `cfg_len` in $clog2(depth+1): pixels per pass
- `cfg_kij` in $clog2(kij_max+1): passes per job
- `cfg_relu` in 1: apply ReLU on drain
- `in_valid` in 1, `in_ready` out 1: input handshake
- `in_data` in col*psum_bw: lane i at [psum_bw*(i+1)-1 : psum_bw*i], signed
- `out_valid` out 1, `out_ready` in 1: output handshake
- `out_data` out col*psum_bw: same lane packing as `in_data`
- `busy` out 1: high outside IDLE
- `done` out 1: one-cycle pulse at job completion

## Operation

- States: IDLE, ACC, DRAIN.
- IDLE: `in_ready`=0, `out_valid`=0. When `cfg_start`=1, latch cfg fields, clear `addr` and `pass`, go to ACC. A `cfg_len` of 0 is treated as 1; a value above `depth` is treated as `depth`. `cfg_kij` is clamped the same way to 1..`kij_max`.
- ACC: `in_ready`=1. On each accept (`in_valid & in_ready`):
  - pass 0: `bank[addr]` = sign-extend(in) per lane.
  - later passes: `bank[addr]` += sign-extend(in), wrapping modulo 2^acc_bw.
  - `addr` increments, wrapping to 0 at `len`; `pass` increments on the wrap.
  - Accepting with `addr`=len-1 and `pass`=kij-1 moves to DRAIN with `addr`=0.
- DRAIN: `in_ready`=0, `out_valid`=1.
  - `out_data` lane = sat(relu ? max(bank[addr],0) : bank[addr]), saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Each handshake advances `addr`. The handshake at `addr`=len-1 returns to IDLE and pulses `done` on the next cycle.
- `cfg_start` is ignored outside IDLE. Bank contents are not cleared by reset or start, because pass 0 overwrites them.

## Timing

- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- Reset asserted mid-job aborts to IDLE on the next edge. No further outputs or `done` are produced for that job.
- `busy` rises the cycle after `cfg_start` is sampled. `in_ready` rises in the same cycle.
- ACC accepts one vector per cycle at full rate with no bubbles.
- The first `out_valid` appears the cycle after the final input is accepted.
- `out_data` is combinational from `bank[addr]` and is held stable while `out_valid & !out_ready`.
- DRAIN sustains one vector per cycle when `out_ready` is held high. Total job length is len*kij + len cycles at full throughput.
- `done` is high in the cycle where state is IDLE again. A `cfg_start` in that same cycle is accepted.

## Structure

- Package `sfp_pkg`:
  - state enum (IDLE/ACC/DRAIN)
  - `sat_to_psum` function
  - a localparam giving the default `acc_bw` headroom of 4
- Sub-module `sfp_lane` (`psum_bw`, `acc_bw`):
  - per-channel extend/add/select
  - ReLU and saturation
  - instantiated `col` times by a generate loop
- Top-level contents: FSM, counters, handshakes, and the `depth`×`col`×`acc_bw` register bank.

## Test plan

- Reset: hold `reset`=0 for 3 cycles with random inputs → all outputs 0, state IDLE; `in_valid` is ignored.
- Basic accumulation: len=4, kij=3, relu=0, every lane fed 5, then 7, then -2 at each pixel → 4 outputs of 10 per lane; `done` pulses once; job takes 16 cycles with `out_ready`=1.
- ReLU and saturation: len=2, kij=2, relu=1; lane 0 fed -100,-100; lane 1 fed 30000,30000 → lane 0 = 0, lane 1 = 32767. With relu=0, lane 0 = -200.
- Backpressure: toggle `out_ready` randomly during DRAIN → `out_data` is stable whenever `out_valid & !out_ready`; no output is lost or duplicated.
- Clamping and input stalls: `cfg_len`=0 and `cfg_kij`=0 → exactly 1 input accepted and 1 output produced. `cfg_len`=20 with depth=16 → 16 outputs. Random `in_valid` gaps → results unchanged.
- Abort and restart: drive `reset` low during ACC pass 1, then start a new job with len=3, kij=1 → outputs equal the new inputs exactly, with no stale accumulation.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared types and helpers for the accumulate/ReLU/saturate output stage.
package sfp_pkg;

  // Job control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Default accumulator growth above the psum width.
  localparam int ACC_HEADROOM = 4;

  // Clamp a signed value into the signed range of a psum_bw-bit word.
  function automatic logic signed [63:0] sat_to_psum(input logic signed [63:0] value,
                                                     input int psum_bw);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (psum_bw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (psum_bw - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One channel of the bank datapath: extend/accumulate on the way in,
// ReLU and saturation on the way out.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int acc_bw  = psum_bw + ACC_HEADROOM
) (
  input  logic signed [psum_bw-1:0] in_psum,
  input  logic signed [acc_bw-1:0]  acc_cur,
  input  logic                      first_pass,
  input  logic                      relu,
  output logic signed [acc_bw-1:0]  acc_next,
  output logic        [psum_bw-1:0] out_psum
);

  logic signed [acc_bw-1:0] ext;
  logic signed [acc_bw-1:0] relu_val;

  // Accumulate path and drain path share the same bank entry.
  always_comb begin
    ext      = acc_bw'(in_psum);
    acc_next = first_pass ? ext : acc_cur + ext;
    relu_val = (relu && acc_cur[acc_bw-1]) ? '0 : acc_cur;
    out_psum = psum_bw'(sat_to_psum(64'(relu_val), psum_bw));
  end

endmodule

// File: rtl/sfp_acc_bank.sv
// Multi-channel accumulation bank: accumulates kij passes of len pixels,
// then drains ReLU'd, saturated results under valid/ready.
module sfp_acc_bank
  import sfp_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = psum_bw + ACC_HEADROOM,
  parameter int depth   = 16,
  parameter int kij_max = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [$clog2(depth+1)-1:0]    cfg_len,
  input  logic [$clog2(kij_max+1)-1:0]  cfg_kij,
  input  logic                          cfg_relu,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [col*psum_bw-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [col*psum_bw-1:0]        out_data,
  output logic                          busy,
  output logic                          done
);

  localparam int LEN_W  = $clog2(depth + 1);
  localparam int KIJ_W  = $clog2(kij_max + 1);
  localparam int ADDR_W = (depth > 1) ? $clog2(depth) : 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [KIJ_W-1:0]   pass_q, pass_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [KIJ_W-1:0]   kij_q, kij_d;
  logic               relu_q, relu_d;
  logic               done_q, done_d;

  logic signed [acc_bw-1:0]  bank_q [depth][col];
  logic signed [acc_bw-1:0]  acc_next [col];
  logic        [psum_bw-1:0] lane_out [col];

  logic last_addr, last_pass, acc_fire;

  assign last_addr = (LEN_W'(addr_q) == len_q - LEN_W'(1));
  assign last_pass = (pass_q == kij_q - KIJ_W'(1));
  assign acc_fire  = (state_q == ST_ACC) && in_valid;

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DRAIN);
  assign done      = done_q;

  // Next-state and counter logic for the IDLE/ACC/DRAIN sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    len_d   = len_q;
    kij_d   = kij_q;
    relu_d  = relu_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          len_d   = (cfg_len == '0) ? LEN_W'(1) :
                    ((cfg_len > LEN_W'(depth)) ? LEN_W'(depth) : cfg_len);
          kij_d   = (cfg_kij == '0) ? KIJ_W'(1) :
                    ((cfg_kij > KIJ_W'(kij_max)) ? KIJ_W'(kij_max) : cfg_kij);
          relu_d  = cfg_relu;
          addr_d  = '0;
          pass_d  = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          if (last_addr) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            if (last_pass) state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (last_addr) begin
            addr_d  = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pass_q  <= '0;
      len_q   <= '0;
      kij_q   <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      len_q   <= len_d;
      kij_q   <= kij_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
    end
  end

  // Bank write on every accepted input vector.
  always_ff @(posedge clk) begin
    // NOTE: the bank has no reset; pass 0 overwrites every entry before it is read.
    if (reset && acc_fire) begin
      for (int i = 0; i < col; i++) bank_q[addr_q][i] <= acc_next[i];
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(
      .psum_bw (psum_bw),
      .acc_bw  (acc_bw)
    ) u_lane (
      .in_psum    (in_data[i*psum_bw +: psum_bw]),
      .acc_cur    (bank_q[addr_q][i]),
      .first_pass (pass_q == '0),
      .relu       (relu_q),
      .acc_next   (acc_next[i]),
      .out_psum   (lane_out[i])
    );
    assign out_data[i*psum_bw +: psum_bw] = out_valid ? lane_out[i] : '0;
  end

endmodule

// File: tb/tb_sfp_acc_bank.sv
// Scoreboard bench for sfp_acc_bank with an arithmetic reference model.
module tb_sfp_acc_bank;

  localparam int COL   = 8;
  localparam int PB    = 16;
  localparam int AB    = 20;
  localparam int DEPTH = 16;
  localparam int KMAX  = 9;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int KW    = $clog2(KMAX + 1);
  localparam int W     = COL * PB;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [LW-1:0] cfg_len;
  logic [KW-1:0] cfg_kij;
  logic          cfg_relu;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;

  sfp_acc_bank #(
    .col(COL), .psum_bw(PB), .acc_bw(AB), .depth(DEPTH), .kij_max(KMAX)
  ) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_kij(cfg_kij), .cfg_relu(cfg_relu), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int out_cnt  = 0;
  bit bp_mode  = 1'b0;

  logic [W-1:0] stim [$];
  logic [W-1:0] exp_q [$];
  logic         hold_q = 1'b0;
  logic [W-1:0] hold_data;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int maxv);
    if (v == 0) return 1;
    if (v > maxv) return maxv;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int l = 0; l < COL; l++) v[l*PB +: PB] = PB'($urandom);
    return v;
  endfunction

  // Reference: sum the pixel over all passes, wrap to the accumulator width,
  // then optional ReLU and clamp to the psum range.
  function automatic logic [W-1:0] model_pixel(input int p, input int len, input int kij,
                                               input bit relu);
    logic [W-1:0]          res;
    logic [W-1:0]          vec;
    logic signed [PB-1:0]  x;
    longint                s;
    longint                v;
    res = '0;
    for (int l = 0; l < COL; l++) begin
      s = 0;
      for (int k = 0; k < kij; k++) begin
        vec = stim[k*len + p];
        x   = vec[l*PB +: PB];
        s  += longint'(x);
      end
      v = s & ((longint'(1) << AB) - 1);
      if (v >= (longint'(1) << (AB - 1))) v -= (longint'(1) << AB);
      if (relu && v < 0) v = 0;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      res[l*PB +: PB] = v[PB-1:0];
    end
    return res;
  endfunction

  // Output-side ready pattern: always ready, or random backpressure.
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each output handshake and watches
  // hold stability, done placement and busy duration.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset === 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        check("done_in_idle", W'(busy), W'(0));
      end
      if (hold_q && out_valid === 1'b1) check("hold_stable", out_data, hold_data);
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          out_cnt++;
        end
      end
      hold_q    = (out_valid === 1'b1) && !out_ready;
      hold_data = out_data;
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic start_cfg(input int len_cfg, input int kij_cfg, input bit relu);
    cfg_start = 1'b1;
    cfg_len   = LW'(len_cfg);
    cfg_kij   = KW'(kij_cfg);
    cfg_relu  = relu;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_len   = LW'($urandom);
    cfg_kij   = KW'($urandom);
  endtask

  task automatic feed(input int n, input bit stalls);
    int  idx   = 0;
    int  guard = 0;
    bit  acc;
    while (idx < n && guard < 4 * n + 50) begin
      in_valid = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? stim[idx] : rand_vec();
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = rand_vec();
    check("inputs_accepted", W'(idx), W'(n));
  endtask

  task automatic run_job(input int len_cfg, input int kij_cfg, input bit relu,
                         input bit stalls, input bit bp, input bit gen);
    int el, ek, done0, out0;
    bit got_done;
    el = clamp(len_cfg, DEPTH);
    ek = clamp(kij_cfg, KMAX);
    if (gen) begin
      stim.delete();
      repeat (el * ek) stim.push_back(rand_vec());
    end
    for (int p = 0; p < el; p++) exp_q.push_back(model_pixel(p, el, ek, relu));
    done0    = done_cnt;
    out0     = out_cnt;
    busy_cnt = 0;
    bp_mode  = bp;
    start_cfg(len_cfg, kij_cfg, relu);
    feed(el * ek, stalls);
    got_done = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1'b1;
    end
    check("done_seen", W'(got_done), W'(1));
    @(posedge clk); #1;
    bp_mode = 1'b0;
    check("outputs_drained", W'(exp_q.size()), W'(0));
    check("output_count", W'(out_cnt - out0), W'(el));
    check("done_pulses", W'(done_cnt - done0), W'(1));
    if (!stalls && !bp) check("job_cycles", W'(busy_cnt), W'(el * ek + el));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int           d0;
    reset     = 1'b0;
    cfg_start = 1'b0;
    cfg_len   = '0;
    cfg_kij   = '0;
    cfg_relu  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset held with random activity on the inputs.
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      in_valid  = 1'($urandom);
      cfg_start = 1'($urandom);
      in_data   = rand_vec();
      @(negedge clk);
      check("rst_in_ready", W'(in_ready), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_data", out_data, W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      @(posedge clk);
    end
    #1;
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;

    // Basic accumulation: 5, 7, -2 on every lane and pixel.
    stim.delete();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) begin
        for (int l = 0; l < COL; l++) v[l*PB +: PB] = (k == 0) ? 16'sd5 : (k == 1) ? 16'sd7 : -16'sd2;
        stim.push_back(v);
      end
    end
    run_job(4, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // ReLU and saturation, then the same data without ReLU.
    for (int r = 1; r >= 0; r--) begin
      stim.delete();
      for (int i = 0; i < 4; i++) begin
        v = rand_vec();
        v[0*PB +: PB] = -16'sd100;
        v[1*PB +: PB] = 16'sd30000;
        stim.push_back(v);
      end
      run_job(2, 2, 1'(r), 1'b0, 1'b0, 1'b0);
    end

    // Backpressure with random input gaps.
    run_job(8, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    run_job(5, 9, 1'b1, 1'b1, 1'b1, 1'b1);

    // Clamping.
    run_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(20, 12, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(20, 12, 1'b1, 1'b1, 1'b1, 1'b1);

    // Full-rate random jobs.
    for (int j = 0; j < 3; j++)
      run_job($urandom_range(1, DEPTH), $urandom_range(1, KMAX), 1'($urandom), 1'b0, 1'b0, 1'b1);

    // Abort during pass 1, then a fresh single-pass job.
    stim.delete();
    repeat (6) stim.push_back(rand_vec());
    d0 = done_cnt;
    start_cfg(4, 3, 1'b0);
    feed(6, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = rand_vec();
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), W'(0));
    check("abort_in_ready", W'(in_ready), W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", W'(done_cnt - d0), W'(0));
    run_job(3, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
